link_sync_supervisor: RTL and testbench

Link bring-up controller that sequences the PCS receive synchronization block. It holds the synchronization block in power-on during startup, then waits for code_sync_status and qualifies it over a stable window before declaring link_up. On a sync timeout it retries with a reset pulse; after MAX_RETRIES consecutive failed retries it reports a sticky link failure. It sits between host/management control and the synchronization block's power_on / mr_main_reset inputs.

---
 rtl/link_sync_supervisor_pkg.sv | 34 +++
 rtl/link_sync_supervisor_timer.sv | 28 ++
 rtl/link_sync_supervisor.sv | 149 ++++++++++++++
 tb/tb_link_sync_supervisor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/link_sync_supervisor_pkg.sv
// Shared definitions for the link bring-up supervisor and the receive
// synchronization block it controls.
package link_sync_supervisor_pkg;

  // State codes are visible on state_dbg, so they are fixed numbers.
  localparam logic [2:0] ST_DISABLED  = 3'd0;
  localparam logic [2:0] ST_POWER_UP  = 3'd1;
  localparam logic [2:0] ST_WAIT_SYNC = 3'd2;
  localparam logic [2:0] ST_QUALIFY   = 3'd3;
  localparam logic [2:0] ST_LINK_UP   = 3'd4;
  localparam logic [2:0] ST_RETRY     = 3'd5;
  localparam logic [2:0] ST_FAILED    = 3'd6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic OK    = 1'b0;
  localparam logic FAIL  = 1'b1;

  typedef enum logic [2:0] {
    DISABLED  = ST_DISABLED,
    POWER_UP  = ST_POWER_UP,
    WAIT_SYNC = ST_WAIT_SYNC,
    QUALIFY   = ST_QUALIFY,
    LINK_UP   = ST_LINK_UP,
    RETRY     = ST_RETRY,
    FAILED    = ST_FAILED
  } state_t;

  // Retry counter saturates rather than wrapping back to zero.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/link_sync_supervisor_timer.sv
// Shared state timer: up-counter with synchronous clear, a terminal match
// against a per-state limit, and an out-of-range flag for recovery.
module link_timer #(
  parameter int CNT_W = 10
) (
  input  logic             Clk,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             match_o,
  output logic             over_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count up when asked; hold at all-ones so the counter can never wrap.
  always_ff @(posedge Clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_o = (cnt_q == limit_i);
  assign over_o  = (cnt_q > limit_i);

endmodule

// File: rtl/link_sync_supervisor.sv
// Link bring-up supervisor: powers up the receive synchronization block,
// waits for code sync, qualifies it over a window, retries on timeout and
// latches a failure once retries are exhausted.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DISABLED  | link disabled, sync block held in power_on
// POWER_UP  | power_on held for POWER_ON_CYCLES
// WAIT_SYNC | waiting for code_sync_status, bounded by SYNC_TIMEOUT
// QUALIFY   | code_sync_status must stay high LINK_TIMER samples
// LINK_UP   | link qualified and in sync
// RETRY     | one-cycle sync_reset pulse, retry_cnt bumped
// FAILED    | retries exhausted, sticky until enable drops or reset
module link_sync_supervisor
  import link_sync_supervisor_pkg::*;
#(
  parameter int POWER_ON_CYCLES = 4,
  parameter int SYNC_TIMEOUT    = 1000,
  parameter int LINK_TIMER      = 16,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 10
) (
  input  logic       Clk,
  input  logic       mr_main_reset,
  input  logic       enable,
  input  logic       code_sync_status,
  output logic       power_on,
  output logic       sync_reset,
  output logic       link_up,
  output logic       link_fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] LIM_PWR  = CNT_W'(POWER_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_SYNC = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIM_LINK = CNT_W'(LINK_TIMER - 1);
  localparam logic [1:0]       MAX_R    = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic             power_on_q, sync_reset_q, link_up_q, link_fail_q;
  logic [1:0]       retry_cnt_q;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_clr, tmr_inc, tmr_match, tmr_over;

  // Timer limit and count enable depend only on the current state; in
  // QUALIFY the timer counts only samples with sync status high.
  always_comb begin
    tmr_limit = '0;
    tmr_inc   = FALSE;
    case (state_q)
      POWER_UP: begin
        tmr_limit = LIM_PWR;
        tmr_inc   = TRUE;
      end
      WAIT_SYNC: begin
        tmr_limit = LIM_SYNC;
        tmr_inc   = TRUE;
      end
      QUALIFY: begin
        tmr_limit = LIM_LINK;
        tmr_inc   = code_sync_status;
      end
      default: begin
        tmr_limit = '0;
        tmr_inc   = FALSE;
      end
    endcase
  end

  // Next-state decision: enable low, then a corrupted timer, then local arcs.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = DISABLED;
    end else if (tmr_over) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED:  state_d = POWER_UP;
        POWER_UP:  if (tmr_match) state_d = WAIT_SYNC;
        WAIT_SYNC: begin
          if (code_sync_status) begin
            state_d = QUALIFY;
          end else if (tmr_match) begin
            state_d = (retry_cnt_q == MAX_R) ? FAILED : RETRY;
          end
        end
        RETRY:     state_d = WAIT_SYNC;
        QUALIFY: begin
          if (!code_sync_status) begin
            state_d = WAIT_SYNC;
          end else if (tmr_match) begin
            state_d = LINK_UP;
          end
        end
        LINK_UP:   if (!code_sync_status) state_d = WAIT_SYNC;
        FAILED:    state_d = FAILED;
        default:   state_d = DISABLED;
      endcase
    end
  end

  // Timer restarts on every state change so each state sees a fresh count.
  assign tmr_clr = mr_main_reset || (state_d != state_q);

  link_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .Clk     (Clk),
    .clr_i   (tmr_clr),
    .inc_i   (tmr_inc),
    .limit_i (tmr_limit),
    .match_o (tmr_match),
    .over_o  (tmr_over)
  );

  // State register plus outputs decoded from the next state, so each
  // output is already correct in the first cycle of its state.
  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      state_q      <= DISABLED;
      power_on_q   <= TRUE;
      sync_reset_q <= FALSE;
      link_up_q    <= FALSE;
      link_fail_q  <= OK;
      retry_cnt_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      power_on_q   <= (state_d == DISABLED) || (state_d == POWER_UP);
      sync_reset_q <= (state_d == RETRY);
      link_up_q    <= (state_d == LINK_UP);
      link_fail_q  <= (state_d == FAILED) ? FAIL : OK;
      case (state_d)
        DISABLED, LINK_UP: retry_cnt_q <= 2'd0;
        RETRY:             retry_cnt_q <= sat_inc2(retry_cnt_q);
        default:           retry_cnt_q <= retry_cnt_q;
      endcase
    end
  end

  assign power_on   = power_on_q;
  assign sync_reset = sync_reset_q;
  assign link_up    = link_up_q;
  assign link_fail  = link_fail_q;
  assign retry_cnt  = retry_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_link_sync_supervisor.sv
// Directed bench for link_sync_supervisor with a queue-based scoreboard of
// expected output vectors {state, power_on, sync_reset, link_up, link_fail, retry_cnt}.
module tb_link_sync_supervisor;

  logic       Clk;
  logic       mr_main_reset;
  logic       enable;
  logic       code_sync_status;
  logic       power_on;
  logic       sync_reset;
  logic       link_up;
  logic       link_fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  link_sync_supervisor dut (
    .Clk              (Clk),
    .mr_main_reset    (mr_main_reset),
    .enable           (enable),
    .code_sync_status (code_sync_status),
    .power_on         (power_on),
    .sync_reset       (sync_reset),
    .link_up          (link_up),
    .link_fail        (link_fail),
    .retry_cnt        (retry_cnt),
    .state_dbg        (state_dbg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [8:0] ev(input int st, input bit po, input bit sr,
                                    input bit lu, input bit lf, input int rc);
    return {3'(st), po, sr, lu, lf, 2'(rc)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_head();
    logic [8:0] got;
    logic [8:0] ex;
    string      tag;
    ex  = exp_q.pop_front();
    tag = tag_q.pop_front();
    got = {state_dbg, power_on, sync_reset, link_up, link_fail, retry_cnt};
    total++;
    assert (got === ex) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, ex);
    end
  endtask

  // Queue the expectation for the next edge, advance one cycle, compare.
  task automatic step(input string tag, input logic [8:0] ex);
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    tick();
    check_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mr_main_reset    = 1'b1;
    enable           = 1'b0;
    code_sync_status = 1'b0;
    run(2);
    step("reset", ev(0, 1, 0, 0, 0, 0));
    mr_main_reset = 1'b0;

    // Clean bring-up with status high from the first WAIT_SYNC cycle.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step("t1_power_up", ev(1, 1, 0, 0, 0, 0));
    step("t1_wait_sync", ev(2, 0, 0, 0, 0, 0));
    code_sync_status = 1'b1;
    step("t1_qual_entry", ev(3, 0, 0, 0, 0, 0));
    for (int i = 1; i < 16; i++) step("t1_qual", ev(3, 0, 0, 0, 0, 0));
    step("t1_link_up", ev(4, 0, 0, 1, 0, 0));
    step("t1_link_hold", ev(4, 0, 0, 1, 0, 0));

    // Reset while the link is up.
    mr_main_reset = 1'b1;
    step("t6_rst_linkup", ev(0, 1, 0, 0, 0, 0));
    mr_main_reset = 1'b0;

    // Qualification broken on sample 10, then a full window again.
    for (int i = 0; i < 4; i++) step("t3_power_up", ev(1, 1, 0, 0, 0, 0));
    step("t3_wait_sync", ev(2, 0, 0, 0, 0, 0));
    step("t3_qual_entry", ev(3, 0, 0, 0, 0, 0));
    for (int i = 1; i < 10; i++) step("t3_qual", ev(3, 0, 0, 0, 0, 0));
    code_sync_status = 1'b0;
    step("t3_drop", ev(2, 0, 0, 0, 0, 0));
    code_sync_status = 1'b1;
    step("t3_requal_entry", ev(3, 0, 0, 0, 0, 0));
    for (int i = 1; i < 16; i++) step("t3_requal", ev(3, 0, 0, 0, 0, 0));
    step("t3_link_up", ev(4, 0, 0, 1, 0, 0));

    // Loss of sync in LINK_UP, then a full timeout before the first retry.
    code_sync_status = 1'b0;
    step("t4_drop", ev(2, 0, 0, 0, 0, 0));
    run(998);
    step("t4_wait_end", ev(2, 0, 0, 0, 0, 0));
    step("t4_retry", ev(5, 0, 1, 0, 0, 1));
    step("t4_after_retry", ev(2, 0, 0, 0, 0, 1));

    // Status arrives in the same cycle as the timeout: sync wins.
    run(998);
    step("t5_wait_end", ev(2, 0, 0, 0, 0, 1));
    code_sync_status = 1'b1;
    step("t5_qual_wins", ev(3, 0, 0, 0, 0, 1));
    step("t5_no_pulse", ev(3, 0, 0, 0, 0, 1));

    // Reset in the middle of the sync_reset pulse.
    code_sync_status = 1'b0;
    step("t6_wait", ev(2, 0, 0, 0, 0, 1));
    run(998);
    step("t6_wait_end", ev(2, 0, 0, 0, 0, 1));
    step("t6_retry", ev(5, 0, 1, 0, 0, 2));
    mr_main_reset = 1'b1;
    step("t6_rst_retry", ev(0, 1, 0, 0, 0, 0));
    step("t6_rst_hold", ev(0, 1, 0, 0, 0, 0));
    mr_main_reset = 1'b0;
    enable        = 1'b0;
    step("t6_disabled", ev(0, 1, 0, 0, 0, 0));

    // Retries exhausted with status stuck low.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step("t2_power_up", ev(1, 1, 0, 0, 0, 0));
    step("t2_wait_sync", ev(2, 0, 0, 0, 0, 0));
    for (int r = 1; r <= 3; r++) begin
      run(998);
      step("t2_wait_end", ev(2, 0, 0, 0, 0, r - 1));
      step("t2_retry", ev(5, 0, 1, 0, 0, r));
      step("t2_wait_again", ev(2, 0, 0, 0, 0, r));
    end
    run(998);
    step("t2_last_wait", ev(2, 0, 0, 0, 0, 3));
    step("t2_failed", ev(6, 0, 0, 0, 1, 3));
    code_sync_status = 1'b1;
    step("t2_failed_sticky", ev(6, 0, 0, 0, 1, 3));
    step("t2_failed_sticky2", ev(6, 0, 0, 0, 1, 3));
    enable = 1'b0;
    step("t2_disable", ev(0, 1, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
